// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, req/ack instruction-memory port, valid/ready output to decode.
// Optional IFETCH_PREDECODE_EN: stall after beq/bne until the branch resolves (no wrong-path fetch).
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [1:0]  dbg_state
);

    // Handshakes: a memory word transfers on a cycle with imem_req && imem_ack;
    // an instruction transfers to decode on a cycle with instr_valid && instr_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
`ifdef IFETCH_PREDECODE_EN
        , WAIT_BR = 2'd3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        redirect;
    logic [31:0] target_word;
    logic        unused_target_bits;

    assign target_word        = {br_target[31:2], 2'b00};
    assign unused_target_bits = ^br_target[1:0];
    assign redirect           = br_valid && br_taken && (state_q != IDLE);

`ifdef IFETCH_PREDECODE_EN
    logic is_branch;
    // beq = 000100, bne = 000101
    assign is_branch = (instr_q[31:27] == 5'b00010);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // A same-cycle redirect wins: the returned word is wrong-path.
                if (imem_ack && !redirect) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && instr_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
`ifdef IFETCH_PREDECODE_EN
                    if (is_branch) state_d = WAIT_BR;
`endif
                end
            end
`ifdef IFETCH_PREDECODE_EN
            WAIT_BR: begin
                if (br_valid) state_d = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
        // Redirect applies after any same-cycle decode handshake has been counted.
        if (redirect) begin
            pc_d    = target_word;
            valid_d = 1'b0;
            state_d = FETCH;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_out      = pc_out_q;
    assign dbg_state   = state_q;

endmodule
